// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and frame FSM encoding for the audio DAC path
package audio_pkg;
  localparam logic I2S_LEFT_LEVEL = 1'b0;
  localparam int UNDERRUN_W = 16;
  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} frame_state_e;
endpackage

// File: rtl/audio_pair_fifo.sv
// audio_pair_fifo: synchronous FIFO of stereo pairs with flush and look-ahead level
module audio_pair_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   level_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop = pop_i && !empty_o && !clr_i;
  assign level_nxt_o = clr_i ? '0 : level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
    end else begin
      wptr_q <= do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_q <= do_pop ? rptr_q + AW'(1) : rptr_q;
      level_q <= level_nxt_o;
    end
  end
endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers stereo pairs and shifts them out as I2S slave data
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AUDIO_DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          clear_audio_out_memory,
  input  logic [DATA_WIDTH-1:0]         left_channel_audio_out,
  input  logic [DATA_WIDTH-1:0]         right_channel_audio_out,
  input  logic                          write_audio_out,
  output logic                          audio_out_allowed,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [UNDERRUN_W-1:0]         underrun_count
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = AUDIO_DATA_WIDTH;
  logic [1:0] bclk_sync_q, lrck_sync_q;
  logic bclk_hist_q, lrck_hist_q;
  frame_state_e state_q, state_d;
  logic [AW-1:0] shift_q, shift_d, hold_q, hold_d;
  logic [4:0] cnt_q, cnt_d;
  logic dat_q, dat_d, allowed_q;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic [2*DATA_WIDTH-1:0] pair;
  logic [LW-1:0] level, level_nxt;
  logic full, empty, have, bclk_fall, lrck_edge, load_left, load_right;
  logic unused_bits;
  assign bclk_fall = bclk_hist_q && !bclk_sync_q[1];
  assign lrck_edge = lrck_hist_q != lrck_sync_q[1];
  assign load_left = lrck_edge && lrck_sync_q[1] == I2S_LEFT_LEVEL;
  // rising LRCK only counts once a left slot has been framed
  assign load_right = lrck_edge && lrck_sync_q[1] != I2S_LEFT_LEVEL && state_q == LEFT;
  assign have = !empty && !clear_audio_out_memory;
  audio_pair_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(CLOCK_50),
    .rst_i(reset),
    .clr_i(clear_audio_out_memory),
    .push_i(write_audio_out && allowed_q),
    .pop_i(load_left),
    .wdata_i({left_channel_audio_out, right_channel_audio_out}),
    .rdata_o(pair),
    .full_o(full),
    .empty_o(empty),
    .level_o(level),
    .level_nxt_o(level_nxt)
  );
  assign unused_bits = ^{full, pair[DATA_WIDTH-AW-1:0], pair[2*DATA_WIDTH-AW-1:DATA_WIDTH]};
  always_comb begin
    state_d = load_left ? LEFT : load_right ? RIGHT : state_q;
    shift_d = shift_q;
    hold_d = hold_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    underrun_d = underrun_q;
    if (load_left) begin
      shift_d = have ? pair[2*DATA_WIDTH-1 -: AW] : '0;
      hold_d = have ? pair[DATA_WIDTH-1 -: AW] : '0;
      cnt_d = '0;
      underrun_d = (!have && underrun_q != '1) ? underrun_q + UNDERRUN_W'(1) : underrun_q;
    end else if (load_right) begin
      shift_d = hold_q;
      cnt_d = '0;
    end else if (bclk_fall) begin
      dat_d = cnt_q < 5'(AW) ? shift_q[AW-1] : 1'b0;
      shift_d = shift_q << 1;
      cnt_d = cnt_q < 5'(AW) ? cnt_q + 5'd1 : cnt_q;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_hist_q <= 1'b0;
      lrck_hist_q <= 1'b0;
      state_q <= WAIT_SYNC;
      shift_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
      dat_q <= 1'b0;
      allowed_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], AUD_DACLRCK};
      bclk_hist_q <= bclk_sync_q[1];
      lrck_hist_q <= lrck_sync_q[1];
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      allowed_q <= level_nxt < LW'(FIFO_DEPTH);
      underrun_q <= underrun_d;
    end
  end
  assign audio_out_allowed = allowed_q;
  assign AUD_DACDAT = dat_q;
  assign fifo_level = level;
  assign underrun_count = underrun_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: directed vectors against a bench-side I2S codec model
module tb_audio_dac_serializer;
  logic CLOCK_50 = 1'b0;
  logic reset, clear_audio_out_memory, write_audio_out;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic audio_out_allowed, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
  logic [2:0] fifo_level;
  logic [15:0] underrun_count;
  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;
  vec_t tv [5];
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] cl, cr;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_dac_serializer dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .clear_audio_out_memory(clear_audio_out_memory),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out(write_audio_out),
    .audio_out_allowed(audio_out_allowed),
    .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT),
    .fifo_level(fifo_level),
    .underrun_count(underrun_count)
  );

  // codec samples one bit per BCLK rise: slot bit 0 is the I2S delay bit, then 24 data bits, then zeros
  function automatic logic [31:0] ex(input logic [23:0] d);
    return {1'b0, d, 7'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    @(negedge CLOCK_50);
    left_channel_audio_out = l;
    right_channel_audio_out = r;
    write_audio_out = 1'b1;
    @(negedge CLOCK_50);
    write_audio_out = 1'b0;
  endtask

  task automatic slot(input logic lr, input int rst_k, output logic [31:0] cap);
    cap = '0;
    for (int k = 0; k < 32; k++) begin
      AUD_BCLK = 1'b0;
      if (k == 0) AUD_DACLRCK = lr;
      repeat (8) @(negedge CLOCK_50);
      AUD_BCLK = 1'b1;
      cap = {cap[30:0], AUD_DACDAT};
      if (k == rst_k) begin
        chk("pre_reset_dat", 32'(AUD_DACDAT), 32'd1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("reset_dat", 32'(AUD_DACDAT), 32'd0);
        reset = 1'b0;
        repeat (7) @(negedge CLOCK_50);
      end else begin
        repeat (8) @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic frame(output logic [31:0] l, output logic [31:0] r);
    slot(1'b0, -1, l);
    slot(1'b1, -1, r);
  endtask

  initial begin
    tv[0] = '{32'hA5A5_C300, 32'h0F0F_F000, 24'hA5A5C3, 24'h0F0FF0};
    tv[1] = '{32'h1234_5678, 32'h8765_4321, 24'h123456, 24'h876543};
    tv[2] = '{32'hFFFF_FF00, 32'h0000_01FF, 24'hFFFFFF, 24'h000001};
    tv[3] = '{32'h8000_0000, 32'h0000_0100, 24'h800000, 24'h000001};
    tv[4] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 24'hDEADBE, 24'hCAFEF0};
    reset = 1'b1;
    clear_audio_out_memory = 1'b0;
    write_audio_out = 1'b0;
    left_channel_audio_out = '0;
    right_channel_audio_out = '0;
    AUD_BCLK = 1'b1;
    AUD_DACLRCK = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_allowed", 32'(audio_out_allowed), 32'd0);
    chk("rst_dat", 32'(AUD_DACDAT), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("allowed_after_rst", 32'(audio_out_allowed), 32'd1);

    push(tv[0].l, tv[0].r);
    chk("basic_level1", 32'(fifo_level), 32'd1);
    frame(cl, cr);
    chk("basic_left", cl, ex(tv[0].el));
    chk("basic_right", cr, ex(tv[0].er));
    chk("basic_level0", 32'(fifo_level), 32'd0);
    chk("basic_underrun", 32'(underrun_count), 32'd0);

    for (int i = 0; i < 3; i++) begin
      frame(cl, cr);
      chk("underrun_left", cl, 32'd0);
      chk("underrun_right", cr, 32'd0);
    end
    chk("underrun_count3", 32'(underrun_count), 32'd3);

    @(negedge CLOCK_50);
    for (int i = 1; i <= 5; i++) begin
      left_channel_audio_out = (i < 5) ? tv[i].l : 32'h5555_5555;
      right_channel_audio_out = (i < 5) ? tv[i].r : 32'hAAAA_AAAA;
      write_audio_out = 1'b1;
      @(negedge CLOCK_50);
    end
    write_audio_out = 1'b0;
    chk("full_allowed", 32'(audio_out_allowed), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      frame(cl, cr);
      chk("full_left", cl, ex(tv[i].el));
      chk("full_right", cr, ex(tv[i].er));
    end
    chk("full_drained", 32'(fifo_level), 32'd0);
    chk("full_no_underrun", 32'(underrun_count), 32'd3);

    push(tv[1].l, tv[1].r);
    push(tv[2].l, tv[2].r);
    chk("clr_level2", 32'(fifo_level), 32'd2);
    @(negedge CLOCK_50);
    clear_audio_out_memory = 1'b1;
    write_audio_out = 1'b1;
    left_channel_audio_out = tv[3].l;
    right_channel_audio_out = tv[3].r;
    @(negedge CLOCK_50);
    clear_audio_out_memory = 1'b0;
    write_audio_out = 1'b0;
    chk("clr_level0", 32'(fifo_level), 32'd0);
    chk("clr_allowed", 32'(audio_out_allowed), 32'd1);
    frame(cl, cr);
    chk("clr_left", cl, 32'd0);
    chk("clr_right", cr, 32'd0);
    chk("clr_underrun", 32'(underrun_count), 32'd4);

    push(tv[2].l, tv[2].r);
    push(tv[4].l, tv[4].r);
    slot(1'b0, 10, cl);
    chk("rst_mid_left", cl, 32'h7FE0_0000);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    chk("rst_mid_underrun", 32'(underrun_count), 32'd0);
    slot(1'b1, -1, cr);
    chk("rst_mid_right_ignored", cr, 32'd0);
    push(tv[3].l, tv[3].r);
    frame(cl, cr);
    chk("resume_left", cl, ex(tv[3].el));
    chk("resume_right", cr, ex(tv[3].er));
    chk("resume_underrun", 32'(underrun_count), 32'd0);

    @(negedge CLOCK_50);
    force dut.underrun_q = 16'hFFFE;
    @(negedge CLOCK_50);
    release dut.underrun_q;
    @(negedge CLOCK_50);
    chk("sat_preload", 32'(underrun_count), 32'h0000_FFFE);
    frame(cl, cr);
    chk("sat_reach", 32'(underrun_count), 32'h0000_FFFF);
    frame(cl, cr);
    frame(cl, cr);
    chk("sat_hold", 32'(underrun_count), 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
